// File: rtl/csa_pipe_adder.sv
// -----------------------------------------------------------------------------
// csa_pipe_adder
//   Pipelined carry-select adder/subtractor. The operands are cut into NBLK
//   blocks of BLOCK bits. Each block precomputes its sum and carry for both
//   possible carry-ins in the input stage. Each of the LAT pipeline stages then
//   resolves BPS blocks: the real carry picks one of the two precomputed
//   results, and the carry out of those blocks goes into the stage register.
//   A single global stall (adv) gives valid/ready flow control with
//   backpressure.
//
// Parameters
//   WIDTH  operand/sum width, a multiple of BLOCK
//   BLOCK  bits per carry-select block (>= 2)
//   BPS    blocks resolved per pipeline stage; WIDTH/BLOCK must be a multiple
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   in_valid_i   operand beat present
//   in_ready_o   beat accepted this cycle when in_valid_i is also high
//   a_i, b_i     operands
//   c_in_i       carry into the LSB (ignored when sub_i = 1)
//   sub_i        0: a + b + c_in   1: a - b
//   out_valid_o  result beat present
//   out_ready_i  downstream accepts the result
//   sum_o        result
//   c_out_o      carry out of the MSB (for subtract, 1 = no borrow)
//   ovf_o        signed two's-complement overflow
//   zero_o       sum_o == 0
// -----------------------------------------------------------------------------
module csa_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int BPS   = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int LAT  = NBLK / BPS;

  localparam logic [BLOCK:0] ONE_B = {{BLOCK{1'b0}}, 1'b1};

  if ((BLOCK < 2) || (WIDTH % BLOCK != 0) || (BPS < 1) || (NBLK % BPS != 0)) begin : g_param_err
    $error("csa_pipe_adder: illegal WIDTH/BLOCK/BPS combination");
  end

  // One pipeline slot. The sum field fills up from the LSB end as stages
  // resolve blocks. s0/s1/c0/c1 are the precomputed per-block results for
  // carry-in 0 and carry-in 1. cy is the resolved carry into the next
  // unresolved block. After the last stage it is the carry out of the MSB.
  // pm is a^Beff at the MSB, so the carry into the MSB can be recovered at the
  // end without carrying it separately.
  typedef struct packed {
    logic             vld;
    logic             cy;
    logic             pm;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [NBLK-1:0]  c0;
    logic [NBLK-1:0]  c1;
  } stage_t;

  logic             adv;
  logic [WIDTH-1:0] beff;
  logic [BLOCK:0]   t0;
  logic [BLOCK:0]   t1;
  stage_t           st0;
  stage_t           src [0:LAT-1];
  stage_t           nxt;
  logic             cy;
  stage_t           st_d [1:LAT];
  stage_t           st_q [1:LAT];
  logic             zero_d;
  logic             ovf_d;
  logic             zero_q;
  logic             ovf_q;

  // Global stall: when the output slot is full and not taken, nothing moves.
  assign adv        = ~st_q[LAT].vld | out_ready_i;
  assign in_ready_o = adv;

  // Operand preparation and per-block dual-carry precompute.
  always_comb begin
    beff    = sub_i ? ~b_i : b_i;
    t0      = '0;
    t1      = '0;
    st0     = '0;
    st0.vld = in_valid_i;
    st0.cy  = sub_i | c_in_i;
    st0.pm  = a_i[WIDTH-1] ^ beff[WIDTH-1];
    for (int j = 0; j < NBLK; j++) begin
      t0 = {1'b0, a_i[j*BLOCK +: BLOCK]} + {1'b0, beff[j*BLOCK +: BLOCK]};
      t1 = t0 + ONE_B;
      st0.s0[j*BLOCK +: BLOCK] = t0[BLOCK-1:0];
      st0.s1[j*BLOCK +: BLOCK] = t1[BLOCK-1:0];
      st0.c0[j]                = t0[BLOCK];
      st0.c1[j]                = t1[BLOCK];
    end
  end

  // Carry resolution. Stage k takes the slot from stage k-1 (or from the
  // operand prep for k = 1) and resolves blocks (k-1)*BPS .. k*BPS-1.
  always_comb begin
    src[0] = st0;
    for (int k = 1; k < LAT; k++) begin
      src[k] = st_q[k];
    end
    nxt = '0;
    cy  = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      nxt = src[k-1];
      cy  = src[k-1].cy;
      for (int i = 0; i < BPS; i++) begin
        nxt.sum[((k-1)*BPS+i)*BLOCK +: BLOCK] = cy ? src[k-1].s1[((k-1)*BPS+i)*BLOCK +: BLOCK]
                                                   : src[k-1].s0[((k-1)*BPS+i)*BLOCK +: BLOCK];
        cy = cy ? src[k-1].c1[(k-1)*BPS+i] : src[k-1].c0[(k-1)*BPS+i];
      end
      nxt.cy  = cy;
      st_d[k] = nxt;
    end
    zero_d = ~|st_d[LAT].sum;
    // carry into MSB = pm ^ sum[MSB]; overflow when it differs from carry out
    ovf_d  = st_d[LAT].pm ^ st_d[LAT].sum[WIDTH-1] ^ st_d[LAT].cy;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 1; k <= LAT; k++) begin
        st_q[k] <= '0;
      end
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      for (int k = 1; k <= LAT; k++) begin
        st_q[k] <= st_d[k];
      end
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid_o = st_q[LAT].vld;
  assign sum_o       = st_q[LAT].sum;
  assign c_out_o     = st_q[LAT].cy;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_csa_pipe_adder
//   Drives three instances (BPS = 1, 2, 4; WIDTH 32, BLOCK 8) from shared
//   stimulus. Each instance has its own scoreboard queue. An entry is pushed
//   when that instance accepts a beat and popped when it delivers a result.
// -----------------------------------------------------------------------------
module tb_csa_pipe_adder;

  localparam int W  = 32;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready_w  [NI];
  logic         out_valid_w [NI];
  logic [W-1:0] sum_w       [NI];
  logic         c_out_w     [NI];
  logic         ovf_w       [NI];
  logic         zero_w      [NI];
  int           q_len       [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc_cyc;
    int           acc_sc;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic sb);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   r;
    be = sb ? ~bv : bv;
    r  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, (sb | ci)};
    e.sum     = r[W-1:0];
    e.cout    = r[W];
    e.ovf     = (av[W-1] == be[W-1]) && (r[W-1] != av[W-1]);
    e.zero    = (r[W-1:0] == '0);
    e.acc_cyc = 0;
    e.acc_sc  = 0;
    return e;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int BPS_G = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int LAT_G = (W / 8) / BPS_G;

    csa_pipe_adder #(.WIDTH(W), .BLOCK(8), .BPS(BPS_G)) u_dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready_w[g]),
      .a_i        (a),
      .b_i        (b),
      .c_in_i     (c_in),
      .sub_i      (sub),
      .out_valid_o(out_valid_w[g]),
      .out_ready_i(out_ready),
      .sum_o      (sum_w[g]),
      .c_out_o    (c_out_w[g]),
      .ovf_o      (ovf_w[g]),
      .zero_o     (zero_w[g])
    );

    exp_t         q[$];
    exp_t         e;
    int           cyc = 0;
    int           sc = 0;
    logic         stall_pend = 1'b0;
    logic [W+3:0] held = '0;

    // Sampling on the falling edge sees exactly what the next rising edge sees.
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        stall_pend = 1'b0;
      end else begin
        if (out_valid_w[g] && out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("bps%0d spurious_result", BPS_G), 64'(1), 64'(0));
          end else begin
            e = q.pop_front();
            chk($sformatf("bps%0d sum", BPS_G),   64'(sum_w[g]),   64'(e.sum));
            chk($sformatf("bps%0d c_out", BPS_G), 64'(c_out_w[g]), 64'(e.cout));
            chk($sformatf("bps%0d ovf", BPS_G),   64'(ovf_w[g]),   64'(e.ovf));
            chk($sformatf("bps%0d zero", BPS_G),  64'(zero_w[g]),  64'(e.zero));
            chk($sformatf("bps%0d latency", BPS_G), 64'(cyc - e.acc_cyc),
                64'(LAT_G + sc - e.acc_sc));
          end
        end
        if (stall_pend) begin
          chk($sformatf("bps%0d stall_stable", BPS_G),
              64'({out_valid_w[g], sum_w[g], c_out_w[g], ovf_w[g], zero_w[g]}), 64'(held));
        end
        stall_pend = out_valid_w[g] && !out_ready;
        held       = {out_valid_w[g], sum_w[g], c_out_w[g], ovf_w[g], zero_w[g]};
        if (in_valid && in_ready_w[g]) begin
          e         = model(a, b, c_in, sub);
          e.acc_cyc = cyc;
          e.acc_sc  = sc;
          q.push_back(e);
        end
        if (!in_ready_w[g]) sc++;
      end
      q_len[g] = q.size();
      cyc++;
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sb);
    @(posedge clk);
    #1;
    a        = av;
    b        = bv;
    c_in     = ci;
    sub      = sb;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for several edges with a beat presented.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = $urandom;
    b         = $urandom;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst out_valid[%0d]", i), 64'(out_valid_w[i]), 64'(0));
      chk($sformatf("rst sum[%0d]", i),       64'(sum_w[i]),       64'(0));
      chk($sformatf("rst c_out[%0d]", i),     64'(c_out_w[i]),     64'(0));
      chk($sformatf("rst ovf[%0d]", i),       64'(ovf_w[i]),       64'(0));
      chk($sformatf("rst zero[%0d]", i),      64'(zero_w[i]),      64'(0));
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("post_rst in_ready[%0d]", i), 64'(in_ready_w[i]), 64'(1));
    end

    // Directed carry/borrow/overflow corners.
    send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    send(32'h00000005, 32'h00000007, 1'b1, 1'b1);
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    send(32'h00000000, 32'h00000000, 1'b0, 1'b1);
    send(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    idle(8);

    // Full throughput: one beat in and one result out every cycle.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = $urandom;
      b         = $urandom;
      c_in      = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int j = 0; j < NI; j++) begin
        chk($sformatf("tput in_ready[%0d]", j), 64'(in_ready_w[j]), 64'(1));
        if (i >= 4) chk($sformatf("tput out_valid[%0d]", j), 64'(out_valid_w[j]), 64'(1));
      end
    end
    idle(8);

    // Random stream with random valid and backpressure.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 65);
      a         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : W'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? 32'h00000000 : W'($urandom);
      c_in      = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
    end
    idle(10);

    // Reset with beats in flight; a beat offered during reset is not taken.
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    send(32'h33333333, 32'h44444444, 1'b1, 1'b0);
    send(32'h55555555, 32'h66666666, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("midrst out_valid[%0d]", i), 64'(out_valid_w[i]), 64'(0));
    end
    send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    idle(8);

    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("drained queue[%0d]", i), 64'(q_len[i]), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
